// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate D-cache: hits complete in the same cycle, misses stall through MISS/WRITEBACK/REFILL/REFILL_DONE.
// Backpressure: cpu_stall_o freezes the pipeline; mem_enable_o stays high until a one-cycle mem_ack_i.
module dcache_controller #(
    parameter int SETS   = 16,
    parameter int LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_write_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - 5;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        REFILL,
        REFILL_DONE
    } state_t;

    state_t state, state_nxt;

    logic [SETS-1:0]   valid;
    logic [SETS-1:0]   dirty;
    logic [TAG_W-1:0]  tags  [SETS];
    logic [LINE_W-1:0] lines [SETS];

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [2:0]       req_word;
    logic             hit;
    logic             write_hit;
    logic             refill_ack;
    logic             unused_addr_lsb;

    assign req_tag         = cpu_addr_i[31 -: TAG_W];
    assign req_idx         = cpu_addr_i[5 +: IDX_W];
    assign req_word        = cpu_addr_i[4:2];
    assign unused_addr_lsb = ^cpu_addr_i[1:0];

    assign hit        = cpu_req_i && valid[req_idx] && (tags[req_idx] == req_tag);
    assign write_hit  = (state == IDLE) && hit && cpu_write_i;
    assign refill_ack = (state == REFILL) && mem_ack_i;

    assign cpu_rdata_o = lines[req_idx][{req_word, 5'b0} +: 32];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
        end else begin
            state <= state_nxt;
            if (refill_ack) begin
                valid[req_idx] <= 1'b1;
                dirty[req_idx] <= 1'b0;
            end else if (write_hit) begin
                dirty[req_idx] <= 1'b1;
            end
        end
    end

    // Tag and line storage carry no reset; valid bits gate every use.
    always_ff @(posedge clk_i) begin
        if (refill_ack) begin
            lines[req_idx] <= mem_rdata_i;
            tags[req_idx]  <= req_tag;
        end else if (write_hit) begin
            lines[req_idx][{req_word, 5'b0} +: 32] <= cpu_wdata_i;
        end
    end

    always_comb begin
        state_nxt    = state;
        cpu_stall_o  = 1'b0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        case (state)
            IDLE: begin
                if (cpu_req_i && !hit) begin
                    cpu_stall_o = 1'b1;
                    state_nxt   = MISS;
                end
            end
            MISS: begin
                cpu_stall_o = 1'b1;
                state_nxt   = (valid[req_idx] && dirty[req_idx]) ? WRITEBACK : REFILL;
            end
            WRITEBACK: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tags[req_idx], req_idx, 5'b0};
                mem_wdata_o  = lines[req_idx];
                if (mem_ack_i) begin
                    state_nxt = REFILL;
                end
            end
            REFILL: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {req_tag, req_idx, 5'b0};
                if (mem_ack_i) begin
                    state_nxt = REFILL_DONE;
                end
            end
            REFILL_DONE: begin
                cpu_stall_o = 1'b1;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data-cache controller between the MEM stage of the pipelined CPU and the off-chip data memory. Holds the tag/valid/dirty arrays and the line storage, serves load/store hits with no stall, and runs the miss sequence (optional dirty write-back, then line refill) while holding the pipeline stalled. It is the sequencer that makes the MEM-stage `MemRead`/`MemWrite` controls safe against a multi-cycle memory.

## Interface
- `SETS`, 16: number of cache lines; the index width is log2(`SETS`) = 4.
- `LINE_W`, 256: line width in bits (32 bytes, 8 words). Must equal the memory data width.
- `clk_i` input 1: the single clock; all state updates on the rising edge.
- `rst_i` input 1: reset; asynchronous, active-low.
- `cpu_req_i` input 1: access request; this is MemRead OR MemWrite of the MEM stage.
- `cpu_write_i` input 1: 1 = store, 0 = load. Meaningful only while `cpu_req_i`=1.
- `cpu_addr_i` input 32: byte address, word aligned. tag=[31:9], index=[8:5], word=[4:2].
- `cpu_wdata_i` input 32: store data.
- `cpu_rdata_o` output 32: load data. Valid when `cpu_req_i`=1, `cpu_write_i`=0 and `cpu_stall_o`=0.
- `cpu_stall_o` output 1: freezes the pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- `mem_enable_o` output 1: memory request, held high until acknowledged.
- `mem_write_o` output 1: 1 = line write (write-back), 0 = line read (refill).
- `mem_addr_o` output 32: line-aligned address; bits [4:0] are always 0.
- `mem_wdata_o` output 256: victim line during write-back.
- `mem_rdata_i` input 256: refill line; sampled on the cycle `mem_ack_i`=1.
- `mem_ack_i` input 1: single-cycle completion strobe from memory.

## Operation
- Per-line state: `valid`, `dirty`, 23-bit tag, 256-bit data. Reset clears all `valid` and `dirty` bits. Tags and data are not reset.
- hit = `cpu_req_i` & `valid[index]` & (`tag[index]` == addr tag). The hit decode is combinational.
- FSM states: IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE. The reset state is IDLE.
- IDLE:
  - No request: nothing happens.
  - Read hit: `cpu_rdata_o` = the selected word, no stall.
  - Write hit: at the clock edge, the selected 32-bit word is replaced with `cpu_wdata_i` and `dirty[index]` is set to 1.
  - Miss: `cpu_stall_o`=1 combinationally in the same cycle, and the next state is MISS.
- MISS: one decision cycle. If the victim line is both valid and dirty, go to WRITEBACK. Otherwise go to REFILL.
- WRITEBACK:
  - Drive `mem_enable_o`=1, `mem_write_o`=1, `mem_addr_o`={victim tag, index, 5'b0}, `mem_wdata_o`=victim data.
  - On `mem_ack_i`, go to REFILL.
- REFILL:
  - Drive `mem_enable_o`=1, `mem_write_o`=0, `mem_addr_o`={request tag, index, 5'b0}.
  - On `mem_ack_i`: data ← `mem_rdata_i`, tag ← request tag, valid ← 1, dirty ← 0. Next state is REFILL_DONE.
- REFILL_DONE: one cycle with stall still asserted, then back to IDLE. In IDLE the held request re-evaluates as a hit and completes there; a store sets dirty on that hit.
- `cpu_stall_o` = (state ≠ IDLE) | (IDLE & `cpu_req_i` & ~hit).
- `mem_enable_o` = 1 only in WRITEBACK and REFILL. `mem_write_o` = 1 only in WRITEBACK.
- The CPU holds its address, data and request stable while stalled. A changed request during a stall is not supported and is not checked.
- A `mem_ack_i` seen outside WRITEBACK or REFILL is ignored.

## Timing
- Hit latency: 0 extra cycles; the load returns in the same cycle.
- Clean miss with memory ack latency L (ack L cycles after enable first rises): stall lasts 1 (IDLE miss) + 1 (MISS) + L (REFILL) + 1 (REFILL_DONE) cycles, then the IDLE hit cycle completes unstalled.
- Dirty miss: add L_wb cycles for WRITEBACK.
- `mem_enable_o` stays continuously high through a state, including the ack cycle. For a dirty miss it is high from WRITEBACK entry to REFILL exit with no gap, and `mem_write_o` and `mem_addr_o` change at the WRITEBACK→REFILL edge.
- Reset values of outputs: `cpu_stall_o`=0, `mem_enable_o`=0, `mem_write_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0. `cpu_rdata_o` is don't-care because no line is valid.
- Reset mid-operation (any state): state goes to IDLE immediately (asynchronous), all lines become invalid, and memory outputs drop to 0. A refill in flight is abandoned and a later `mem_ack_i` is ignored.
- `mem_ack_i` in the first cycle of WRITEBACK or REFILL is legal (L=1).

## Test plan
- Clean read miss: after reset, load 0x0000_0040 with memory returning a line whose word0 is 0xDEAD_BEEF and ack at L=3 → REFILL read to 0x0000_0040, stall for 6 cycles, then `cpu_rdata_o`=0xDEAD_BEEF unstalled; no write-back issued.
- Write hit then read hit: store 0x1234_5678 to 0x44 after that line is resident → no stall; a following load of 0x44 returns 0x1234_5678 with 0 stall.
- Dirty eviction: with a dirty line at 0x40, load 0x240 (same index 2, different tag) → WRITEBACK to 0x40 carrying the modified line, then REFILL from 0x240, with `mem_enable_o` continuously high across the two.
- Ack latency sweep: L ∈ {1, 2, 10} on clean and dirty misses → stall length matches the formulas above exactly.
- Reset during REFILL: assert `rst_i`=0 while waiting on ack → `cpu_stall_o` and `mem_enable_o` go to 0 at once; after release, a load of the same address misses again.
- Conflict thrash: alternate loads of 0x00 and 0x200 → each access misses, no write-backs, and the correct data is returned each time.
